// File: rtl/vga_sync_timing.sv
// 640x480@60 raster timing: free-running h/v counters, line/frame pulses, frame counter.
// Latency: coordinates and start pulses 0 clocks; sync/active strobes c_PIPE_DELAY clocks; free-running, no backpressure.
module vga_sync_timing #(
    parameter int   c_H_VISIBLE   = 640,
    parameter int   c_H_FRONT     = 16,
    parameter int   c_H_SYNC      = 96,
    parameter int   c_H_BACK      = 48,
    parameter int   c_V_VISIBLE   = 480,
    parameter int   c_V_FRONT     = 10,
    parameter int   c_V_SYNC      = 2,
    parameter int   c_V_BACK      = 33,
    parameter logic c_SYNC_ACTIVE = 1'b0,
    parameter int   c_PIPE_DELAY  = 2
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    output logic [11:0] o_X,
    output logic [11:0] o_Y,
    output logic        o_Line_Start,
    output logic        o_Frame_Start,
    output logic [7:0]  o_Frame,
    output logic        o_HSync,
    output logic        o_VSync,
    output logic        o_Active
);

    localparam int c_H_TOTAL    = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int c_V_TOTAL    = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;
    localparam int c_HS_START   = c_H_VISIBLE + c_H_FRONT;
    localparam int c_HS_END     = c_HS_START + c_H_SYNC - 1;
    localparam int c_VS_START   = c_V_VISIBLE + c_V_FRONT;
    localparam int c_VS_END     = c_VS_START + c_V_SYNC - 1;

    if (c_H_TOTAL > 4095 || c_V_TOTAL > 4095) begin : g_bad_total
        $error("vga_sync_timing: line or frame total exceeds 12-bit counter range");
    end
    if (c_PIPE_DELAY < 0 || c_PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_sync_timing: c_PIPE_DELAY must be 0..7");
    end

    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic [7:0]  frame_q, frame_d;
    logic        h_wrap;
    logic        v_wrap;

    always_comb begin
        h_wrap  = (h_q == 12'(c_H_TOTAL - 1));
        v_wrap  = (v_q == 12'(c_V_TOTAL - 1));
        h_d     = h_wrap ? 12'd0 : h_q + 12'd1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_wrap) begin
            v_d = v_wrap ? 12'd0 : v_q + 12'd1;
            if (v_wrap) begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            h_q     <= 12'd0;
            v_q     <= 12'd0;
            frame_q <= 8'd0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    // Strobe vector bit order: [2] hsync, [1] vsync, [0] active.
    logic [2:0] strb;
    logic [2:0] strb_dly;

    always_comb begin
        strb[2] = (h_q >= 12'(c_HS_START)) && (h_q <= 12'(c_HS_END));
        strb[1] = (v_q >= 12'(c_VS_START)) && (v_q <= 12'(c_VS_END));
        strb[0] = (h_q < 12'(c_H_VISIBLE)) && (v_q < 12'(c_V_VISIBLE));
    end

    if (c_PIPE_DELAY == 0) begin : g_no_pipe
        assign strb_dly = strb;
    end else begin : g_pipe
        logic [2:0] pipe_q [0:c_PIPE_DELAY-1];

        always_ff @(posedge i_Clk or posedge i_Reset) begin
            if (i_Reset) begin
                for (int i = 0; i < c_PIPE_DELAY; i++) begin
                    pipe_q[i] <= 3'b000;
                end
            end else begin
                pipe_q[0] <= strb;
                for (int i = 1; i < c_PIPE_DELAY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign strb_dly = pipe_q[c_PIPE_DELAY-1];
    end

    assign o_X           = h_q;
    assign o_Y           = v_q;
    assign o_Frame       = frame_q;
    assign o_Line_Start  = (h_q == 12'd0);
    assign o_Frame_Start = (h_q == 12'd0) && (v_q == 12'd0);
    assign o_HSync       = strb_dly[2] ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
    assign o_VSync       = strb_dly[1] ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
    assign o_Active      = strb_dly[0];

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing: default timing, a shrunken raster for frame-level behaviour,
// and a zero-delay / active-high-sync variant. Expectations are queued by sample index.
module tb_vga_sync_timing;

    logic clk;
    logic rst_a, rst_b, rst_c;

    logic [11:0] ax, ay, bx, by, cx, cy;
    logic        als, afs, ahs, avs, aact;
    logic        bls, bfs, bhs, bvs, bact;
    logic        cls, cfs, chs, cvs, cact;
    logic [7:0]  afr, bfr, cfr;

    // Default 640x480 timing, 2-clock strobe delay, active-low syncs.
    vga_sync_timing dut_a (
        .i_Clk(clk), .i_Reset(rst_a), .o_X(ax), .o_Y(ay),
        .o_Line_Start(als), .o_Frame_Start(afs), .o_Frame(afr),
        .o_HSync(ahs), .o_VSync(avs), .o_Active(aact)
    );

    // Shrunken raster: 16 clocks/line (8+2+3+3), 8 lines/frame (4+1+2+1), 3-clock delay.
    vga_sync_timing #(
        .c_H_VISIBLE(8), .c_H_FRONT(2), .c_H_SYNC(3), .c_H_BACK(3),
        .c_V_VISIBLE(4), .c_V_FRONT(1), .c_V_SYNC(2), .c_V_BACK(1),
        .c_SYNC_ACTIVE(1'b0), .c_PIPE_DELAY(3)
    ) dut_b (
        .i_Clk(clk), .i_Reset(rst_b), .o_X(bx), .o_Y(by),
        .o_Line_Start(bls), .o_Frame_Start(bfs), .o_Frame(bfr),
        .o_HSync(bhs), .o_VSync(bvs), .o_Active(bact)
    );

    // Default timing, no delay, active-high syncs.
    vga_sync_timing #(
        .c_SYNC_ACTIVE(1'b1), .c_PIPE_DELAY(0)
    ) dut_c (
        .i_Clk(clk), .i_Reset(rst_c), .o_X(cx), .o_Y(cy),
        .o_Line_Start(cls), .o_Frame_Start(cfs), .o_Frame(cfr),
        .o_HSync(chs), .o_VSync(cvs), .o_Active(cact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int S_AX = 0, S_AY = 1, S_ALS = 2, S_AFS = 3, S_AHS = 4, S_AVS = 5,
                   S_AACT = 6, S_AFR = 7, S_BX = 8, S_BY = 9, S_BFS = 10, S_BFR = 11,
                   S_BVS = 12, S_BHS = 13, S_BACT = 14, S_BLS = 15, S_CHS = 16,
                   S_CACT = 17, K_AHSLO = 18, K_AACT = 19, K_CHSHI = 20, K_CACT = 21,
                   K_BVSLO = 22, K_BVSRUN = 23, K_BACT = 24, K_BHSLO = 25;

    typedef struct {
        int    n;
        int    sig;
        int    exp;
        string name;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    int   k_ahslo = 0, k_aact = 0, k_chshi = 0, k_cact = 0;
    int   k_bvslo = 0, k_bvsrun = 0, bvs_run = 0, k_bact = 0, k_bhslo = 0;
    chk_t c;
    int   got;

    function automatic void push(input int sn, input int sig, input int exp, input string name);
        chk_t e;
        int   i;
        e.n = sn; e.sig = sig; e.exp = exp; e.name = name;
        i = q.size();
        while (i > 0 && q[i-1].n > sn) i--;
        q.insert(i, e);
    endfunction

    function automatic int get(input int sig);
        case (sig)
            S_AX:     return int'(ax);
            S_AY:     return int'(ay);
            S_ALS:    return int'(als);
            S_AFS:    return int'(afs);
            S_AHS:    return int'(ahs);
            S_AVS:    return int'(avs);
            S_AACT:   return int'(aact);
            S_AFR:    return int'(afr);
            S_BX:     return int'(bx);
            S_BY:     return int'(by);
            S_BFS:    return int'(bfs);
            S_BFR:    return int'(bfr);
            S_BVS:    return int'(bvs);
            S_BHS:    return int'(bhs);
            S_BACT:   return int'(bact);
            S_BLS:    return int'(bls);
            S_CHS:    return int'(chs);
            S_CACT:   return int'(cact);
            K_AHSLO:  return k_ahslo;
            K_AACT:   return k_aact;
            K_CHSHI:  return k_chshi;
            K_CACT:   return k_cact;
            K_BVSLO:  return k_bvslo;
            K_BVSRUN: return k_bvsrun;
            K_BACT:   return k_bact;
            K_BHSLO:  return k_bhslo;
            default:  return -1;
        endcase
    endfunction

    // Sample index of (line y, pixel x) after reset release; sample 12 is the last one under reset.
    function automatic int na(input int y, input int x);
        return 12 + y * 800 + x;
    endfunction
    function automatic int nb(input int f, input int y, input int x);
        return 12 + f * 128 + y * 16 + x;
    endfunction

    task automatic wait_until(input longint t);
        if (t > $time) #(t - $time);
    endtask

    // Monitor: sample n is taken at time 10*n, on the falling edge.
    always @(negedge clk) begin
        n = n + 1;
        if (n >= 812 && n < 1612) begin
            if (!ahs)  k_ahslo++;
            if (aact)  k_aact++;
            if (chs)   k_chshi++;
            if (cact)  k_cact++;
        end
        if (n >= 140 && n < 268) begin
            if (!bvs) begin
                k_bvslo++;
                bvs_run++;
                if (bvs_run > k_bvsrun) k_bvsrun = bvs_run;
            end else begin
                bvs_run = 0;
            end
            if (bact) k_bact++;
        end
        if (n >= 140 && n < 156 && !bhs) k_bhslo++;
        while (q.size() > 0 && q[0].n <= n) begin
            c = q.pop_front();
            checks++;
            if (c.n < n) begin
                errors++;
                $display("FAIL %s: sample %0d was never reached", c.name, c.n);
            end else begin
                got = get(c.sig);
                if (got != c.exp) begin
                    errors++;
                    $display("FAIL %s: sample %0d got %0d expected %0d", c.name, c.n, got, c.exp);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;

        // Reset held for 12 samples: outputs frozen, start pulses high.
        for (int i = 1; i <= 12; i++) begin
            push(i, S_AX, 0, "hold_x");
            push(i, S_AY, 0, "hold_y");
            push(i, S_ALS, 1, "hold_line_start");
            push(i, S_AFS, 1, "hold_frame_start");
            push(i, S_AHS, 1, "hold_hsync");
            push(i, S_AVS, 1, "hold_vsync");
            push(i, S_AACT, 0, "hold_active");
            push(i, S_BFR, 0, "hold_frame");
        end

        // Default timing, first two lines.
        push(na(0, 1), S_AX, 1, "a_x_first_edge");
        push(na(0, 1), S_ALS, 0, "a_ls_x1");
        push(na(0, 1), S_AACT, 0, "a_act_pipe_reset_x1");
        push(na(0, 2), S_AACT, 1, "a_act_x2");
        push(na(0, 641), S_AACT, 1, "a_act_x641");
        push(na(0, 642), S_AACT, 0, "a_act_x642");
        push(na(0, 657), S_AHS, 1, "a_hs_x657");
        push(na(0, 658), S_AHS, 0, "a_hs_first_low_x658");
        push(na(0, 753), S_AHS, 0, "a_hs_last_low_x753");
        push(na(0, 754), S_AHS, 1, "a_hs_x754");
        push(na(0, 799), S_AX, 799, "a_x_799");
        push(na(0, 799), S_AY, 0, "a_y_line0_end");
        push(na(0, 799), S_ALS, 0, "a_ls_x799");
        push(na(1, 0), S_AX, 0, "a_x_wrap");
        push(na(1, 0), S_AY, 1, "a_y_increment");
        push(na(1, 0), S_ALS, 1, "a_ls_line1");
        push(na(1, 0), S_AFS, 0, "a_fs_line1");
        push(na(1, 0), S_AACT, 0, "a_act_line1_x0");
        push(na(1, 1), S_AACT, 0, "a_act_line1_x1");
        push(na(1, 2), S_AACT, 1, "a_act_line1_x2");
        push(na(1, 5), S_AVS, 1, "a_vs_idle");
        push(na(2, 0), K_AHSLO, 96, "a_hsync_low_count");
        push(na(2, 0), K_AACT, 640, "a_active_count");

        // Mid-line asynchronous reset of dut_a at X=300 on line 2 (sample 1912).
        push(na(2, 299), S_AX, 299, "a_pre_reset_x");
        push(na(2, 299), S_AY, 2, "a_pre_reset_y");
        push(1912, S_AX, 0, "a_async_x");
        push(1912, S_AY, 0, "a_async_y");
        push(1912, S_AHS, 1, "a_async_hsync");
        push(1912, S_AVS, 1, "a_async_vsync");
        push(1912, S_AACT, 0, "a_async_active");
        push(1912, S_AFR, 0, "a_async_frame");
        push(1916, S_AX, 1, "a_resume_x1");
        push(1916, S_AY, 0, "a_resume_y");
        push(1917, S_AACT, 1, "a_resume_act");

        // Zero delay, active-high syncs.
        push(na(0, 1), S_CACT, 1, "c_act_x1");
        push(na(0, 639), S_CACT, 1, "c_act_x639");
        push(na(0, 640), S_CACT, 0, "c_act_x640");
        push(na(0, 655), S_CHS, 0, "c_hs_x655");
        push(na(0, 656), S_CHS, 1, "c_hs_x656");
        push(na(0, 751), S_CHS, 1, "c_hs_x751");
        push(na(0, 752), S_CHS, 0, "c_hs_x752");
        push(na(0, 799), S_CACT, 0, "c_act_x799");
        push(na(1, 0), S_CACT, 1, "c_act_line1_x0");
        push(na(2, 0), K_CHSHI, 96, "c_hsync_high_count");
        push(na(2, 0), K_CACT, 640, "c_active_count");

        // Shrunken raster: frame boundary, vsync, active region, frame wrap.
        push(nb(0, 7, 15), S_BX, 15, "b_x_last");
        push(nb(0, 7, 15), S_BY, 7, "b_y_last");
        push(nb(0, 7, 15), S_BFS, 0, "b_fs_before_wrap");
        push(nb(0, 7, 15), S_BFR, 0, "b_frame0");
        push(nb(1, 0, 0), S_BX, 0, "b_x_frame_wrap");
        push(nb(1, 0, 0), S_BY, 0, "b_y_frame_wrap");
        push(nb(1, 0, 0), S_BFS, 1, "b_fs_frame_wrap");
        push(nb(1, 0, 0), S_BFR, 1, "b_frame1");
        push(nb(1, 0, 1), S_BFS, 0, "b_fs_x1");
        push(nb(1, 0, 2), S_BACT, 0, "b_act_x2");
        push(nb(1, 0, 3), S_BACT, 1, "b_act_x3");
        push(nb(1, 3, 10), S_BACT, 1, "b_act_y3_x10");
        push(nb(1, 3, 11), S_BACT, 0, "b_act_y3_x11");
        push(nb(1, 4, 3), S_BACT, 0, "b_act_y4");
        push(nb(1, 2, 0), S_BLS, 1, "b_line_start");
        push(nb(1, 5, 2), S_BVS, 1, "b_vs_before");
        push(nb(1, 5, 3), S_BVS, 0, "b_vs_first_low");
        push(nb(1, 7, 2), S_BVS, 0, "b_vs_last_low");
        push(nb(1, 7, 3), S_BVS, 1, "b_vs_after");
        push(nb(2, 0, 0), K_BVSLO, 32, "b_vsync_low_count");
        push(nb(2, 0, 0), K_BVSRUN, 32, "b_vsync_low_run");
        push(nb(2, 0, 0), K_BACT, 32, "b_active_count");
        push(nb(2, 0, 0), K_BHSLO, 3, "b_hsync_low_per_line");
        push(nb(255, 0, 0), S_BFR, 255, "b_frame255");
        push(nb(255, 7, 15), S_BFR, 255, "b_frame255_end");
        push(nb(256, 0, 0), S_BFR, 0, "b_frame_wrap_to_0");
        push(nb(256, 0, 0), S_BFS, 1, "b_fs_after_256");

        // Mid-frame asynchronous reset of dut_b at X=5, Y=3 of frame 258 (sample 33089).
        push(33088, S_BX, 4, "b_pre_reset_x");
        push(33088, S_BY, 3, "b_pre_reset_y");
        push(33088, S_BFR, 2, "b_pre_reset_frame");
        push(33089, S_BX, 0, "b_async_x");
        push(33089, S_BY, 0, "b_async_y");
        push(33089, S_BFR, 0, "b_async_frame");
        push(33089, S_BHS, 1, "b_async_hsync");
        push(33089, S_BVS, 1, "b_async_vsync");
        push(33089, S_BACT, 0, "b_async_active");
        push(33092, S_BX, 0, "b_released_no_edge");
        push(33093, S_BX, 1, "b_resume_x1");
        push(33093, S_BFR, 0, "b_resume_frame");
        push(33094, S_BACT, 0, "b_resume_act_x2");
        push(33095, S_BACT, 1, "b_resume_act_x3");

        wait_until(122);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        wait_until(10 * 1912 - 3);
        rst_a = 1'b1;
        wait_until(10 * 1914 + 7);
        rst_a = 1'b0;

        wait_until(10 * 33089 - 3);
        rst_b = 1'b1;
        wait_until(10 * 33091 + 7);
        rst_b = 1'b0;

        wait_until(10 * 33100 + 2);
        while (q.size() > 0) begin
            c = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: sample %0d not checked before end of run", c.name, c.n);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
